// File: rtl/id_ex_stage_if.sv
// Decode/hazard-unit to execute-stage bundle: D-side operands and control in,
// E-side registered fields and combinational ALU operands out.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
);
    logic              StallE;
    logic              FlushE;
    logic [XLEN-1:0]   RD1D;
    logic [XLEN-1:0]   RD2D;
    logic [XLEN-1:0]   PCD;
    logic [XLEN-1:0]   PCPlus4D;
    logic [XLEN-1:0]   ImmExtD;
    logic [4:0]        Rs1D;
    logic [4:0]        Rs2D;
    logic [4:0]        RdD;
    logic              RegWriteD;
    logic              MemWriteD;
    logic              JumpD;
    logic              BranchD;
    logic              ALUSrcD;
    logic [1:0]        ResultSrcD;
    logic [CTRL_W-1:0] ALUControlD;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic [XLEN-1:0]   ALUResultM;
    logic [XLEN-1:0]   ResultW;

    logic [XLEN-1:0]   SrcAE;
    logic [XLEN-1:0]   SrcBE;
    logic [XLEN-1:0]   WriteDataE;
    logic [CTRL_W-1:0] ALUControlE;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCPlus4E;
    logic [XLEN-1:0]   ImmExtE;
    logic [4:0]        Rs1E;
    logic [4:0]        Rs2E;
    logic [4:0]        RdE;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              JumpE;
    logic              BranchE;
    logic [1:0]        ResultSrcE;
    logic              ValidE;

    modport slave (
        input  StallE, FlushE, RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
               Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, JumpD, BranchD,
               ALUSrcD, ResultSrcD, ALUControlD, ForwardAE, ForwardBE,
               ALUResultM, ResultW,
        output SrcAE, SrcBE, WriteDataE, ALUControlE, PCE, PCPlus4E,
               ImmExtE, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE,
               BranchE, ResultSrcE, ValidE
    );

    modport master (
        output StallE, FlushE, RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
               Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, JumpD, BranchD,
               ALUSrcD, ResultSrcD, ALUControlD, ForwardAE, ForwardBE,
               ALUResultM, ResultW,
        input  SrcAE, SrcBE, WriteDataE, ALUControlE, PCE, PCPlus4E,
               ImmExtE, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE,
               BranchE, ResultSrcE, ValidE
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding and ALU operand select.
// Latency: 1 cycle D->E, 0 through the forwarding muxes; StallE holds, FlushE bubbles.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pcplus4;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              regwrite;
        logic              memwrite;
        logic              jump;
        logic              branch;
        logic              alusrc;
        logic [1:0]        resultsrc;
        logic [CTRL_W-1:0] aluctrl;
    } ex_t;

    ex_t d_in;
    ex_t ex_q;

    always_comb begin
        d_in.valid     = 1'b1;
        d_in.rd1       = bus.RD1D;
        d_in.rd2       = bus.RD2D;
        d_in.pc        = bus.PCD;
        d_in.pcplus4   = bus.PCPlus4D;
        d_in.imm       = bus.ImmExtD;
        d_in.rs1       = bus.Rs1D;
        d_in.rs2       = bus.Rs2D;
        d_in.rd        = bus.RdD;
        d_in.regwrite  = bus.RegWriteD;
        d_in.memwrite  = bus.MemWriteD;
        d_in.jump      = bus.JumpD;
        d_in.branch    = bus.BranchD;
        d_in.alusrc    = bus.ALUSrcD;
        d_in.resultsrc = bus.ResultSrcD;
        d_in.aluctrl   = bus.ALUControlD;
    end

    // A bubble is all-zero, so rs/rd read as x0 and never match in the hazard unit.
    always_ff @(posedge clk) begin
        if (reset || bus.FlushE) begin
            ex_q <= '0;
        end else if (!bus.StallE) begin
            ex_q <= d_in;
        end
    end

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] write_data;

    // Forward selects are live, so a stalled instruction still picks up fresh results.
    always_comb begin
        case (bus.ForwardAE)
            2'b01:   src_a = bus.ResultW;
            2'b10:   src_a = bus.ALUResultM;
            default: src_a = ex_q.rd1;
        endcase
        case (bus.ForwardBE)
            2'b01:   write_data = bus.ResultW;
            2'b10:   write_data = bus.ALUResultM;
            default: write_data = ex_q.rd2;
        endcase
    end

    assign bus.SrcAE       = src_a;
    assign bus.WriteDataE  = write_data;
    assign bus.SrcBE       = ex_q.alusrc ? ex_q.imm : write_data;
    assign bus.ALUControlE = ex_q.aluctrl;
    assign bus.PCE         = ex_q.pc;
    assign bus.PCPlus4E    = ex_q.pcplus4;
    assign bus.ImmExtE     = ex_q.imm;
    assign bus.Rs1E        = ex_q.rs1;
    assign bus.Rs2E        = ex_q.rs2;
    assign bus.RdE         = ex_q.rd;
    assign bus.RegWriteE   = ex_q.regwrite;
    assign bus.MemWriteE   = ex_q.memwrite;
    assign bus.JumpE       = ex_q.jump;
    assign bus.BranchE     = ex_q.branch;
    assign bus.ResultSrcE  = ex_q.resultsrc;
    assign bus.ValidE      = ex_q.valid;
endmodule
